// File: rtl/arm_pkg.sv
// arm_pkg: shared ALU command codes, NZCV bit indices and reset default.
//   Exports CMD_* (4-bit ALU commands), FLAG_N/Z/C/V bit positions,
//   RESET_FLAGS_DEFAULT, and is_arith/is_logical command classifiers.
package arm_pkg;
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   localparam logic [3:0] RESET_FLAGS_DEFAULT = 4'b0000;

   function automatic logic is_arith(input logic [3:0] cmd);
      return cmd == CMD_ADD || cmd == CMD_ADC || cmd == CMD_SUB || cmd == CMD_SBC;
   endfunction

   function automatic logic is_logical(input logic [3:0] cmd);
      return cmd == CMD_MOV || cmd == CMD_MVN || cmd == CMD_AND ||
             cmd == CMD_ORR || cmd == CMD_EOR;
   endfunction
endpackage

// File: rtl/flag_gen.sv
// flag_gen: combinational NZCV computation from the EX-stage ALU outputs.
//   cmd, result, alu_carry, alu_overflow, shifter_carry in; cur_c/cur_v are
//   the present CPSR C/V, used where the command leaves them untouched.
//   flags out is the candidate NZCV value.
module flag_gen
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       cmd,
   input  logic [WIDTH-1:0] result,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             shifter_carry,
   input  logic             cur_c,
   input  logic             cur_v,
   output logic [3:0]       flags
);
   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = result == '0;
      flags[FLAG_C] = is_arith(cmd) ? alu_carry : is_logical(cmd) ? shifter_carry : cur_c;
      flags[FLAG_V] = is_arith(cmd) ? alu_overflow : cur_v;
   end
endmodule

// File: rtl/status_register_unit.sv
// status_register_unit: CPSR NZCV flags with a one-deep SPSR copy.
//   Inputs: EX-stage ALU outputs qualified by ex_valid/s_en, freeze stall,
//   exc_save/exc_restore exception pulses.
//   Outputs: status_bits (CPSR), spsr_bits (SPSR), status_fwd (next CPSR
//   for ID bypass) and flags_pending (CPSR changes at the next edge).
module status_register_unit
   import arm_pkg::*;
#(
   parameter int         WIDTH       = 32,
   parameter logic [3:0] RESET_FLAGS = RESET_FLAGS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             ex_valid,
   input  logic             s_en,
   input  logic [3:0]       alu_cmd,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             shifter_carry,
   input  logic             exc_save,
   input  logic             exc_restore,
   output logic [3:0]       status_bits,
   output logic [3:0]       status_fwd,
   output logic             flags_pending,
   output logic [3:0]       spsr_bits
);
   logic [3:0] cpsr, spsr, new_flags;
   logic       upd, restore, save;

   flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .cmd          (alu_cmd),
      .result       (alu_result),
      .alu_carry    (alu_carry),
      .alu_overflow (alu_overflow),
      .shifter_carry(shifter_carry),
      .cur_c        (cpsr[FLAG_C]),
      .cur_v        (cpsr[FLAG_V]),
      .flags        (new_flags)
   );

   // Exception return wins over an S-instruction in the same cycle.
   assign upd           = ex_valid & s_en & ~freeze & ~exc_restore;
   assign restore       = exc_restore & ~freeze;
   assign save          = exc_save & ~freeze;
   assign flags_pending = upd | restore;
   assign status_fwd    = restore ? spsr : upd ? new_flags : cpsr;
   assign status_bits   = cpsr;
   assign spsr_bits     = spsr;

   // Save reads the pre-edge CPSR, so save+restore swaps the two copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpsr <= RESET_FLAGS;
         spsr <= RESET_FLAGS;
      end else begin
         cpsr <= status_fwd;
         if (save) spsr <= cpsr;
      end
   end
endmodule
